// File: rtl/player_encoder_pkg.sv
// Shared player-link definitions: frame geometry, state encoding and the ones-complement add.
// Used by both the encoder and the receiving decoder.
package player_link_pkg;

  localparam int          FRAME_WORDS       = 5;
  localparam int          WORD_BITS         = 16;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA55A;

  typedef enum logic [2:0] {
    LINK_IDLE     = 3'd0,
    LINK_HEADER   = 3'd1,
    LINK_DATA     = 3'd2,
    LINK_CHECKSUM = 3'd3,
    LINK_GAP      = 3'd4
  } link_state_e;

  // 16-bit add with the carry out of bit 15 folded back into bit 0.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/player_encoder_if.sv
// Player-link transmit bundle: action-word handshake in, serial frame stream out.
// master = game logic side, slave = encoder side.
interface player_encoder_if;
  import player_link_pkg::*;

  logic [2*WORD_BITS-1:0] info_in;
  logic                   info_valid_in;
  logic                   info_ready_out;
  logic                   data_out;
  logic                   data_valid_out;

  modport master (
    output info_in,
    output info_valid_in,
    input  info_ready_out,
    input  data_out,
    input  data_valid_out
  );

  modport slave (
    input  info_in,
    input  info_valid_in,
    output info_ready_out,
    output data_out,
    output data_valid_out
  );

endinterface

// File: rtl/player_encoder_ones_complement_sum.sv
// Inverted 16-bit end-around-carry sum of four words; purely combinational.
// Also instantiated by the receiver to verify frames.
module ones_complement_sum
  import player_link_pkg::*;
(
  input  logic [WORD_BITS-1:0] w0_i,
  input  logic [WORD_BITS-1:0] w1_i,
  input  logic [WORD_BITS-1:0] w2_i,
  input  logic [WORD_BITS-1:0] w3_i,
  output logic [WORD_BITS-1:0] sum_o
);

  assign sum_o = ~oc_add(oc_add(oc_add(w0_i, w1_i), w2_i), w3_i);

endmodule

// File: rtl/player_encoder.sv
// Serializes one 32-bit action word into an 80-bit MSB-first frame; first bit the cycle after accept.
// Ready only in IDLE (registered); valid while busy is ignored, so the source must hold its word.
module player_encoder
  import player_link_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
  parameter logic [7:0]  PLAYER_ID  = 8'h00,
  parameter int          GAP_CYCLES = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  player_encoder_if.slave  bus
);

  localparam logic [2:0]  IDLE     = 3'(LINK_IDLE);
  localparam logic [2:0]  HEADER   = 3'(LINK_HEADER);
  localparam logic [2:0]  DATA     = 3'(LINK_DATA);
  localparam logic [2:0]  CHECKSUM = 3'(LINK_CHECKSUM);
  localparam logic [2:0]  GAP      = 3'(LINK_GAP);
  localparam logic [2:0]  LAST_WORD = 3'(FRAME_WORDS - 1);
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  logic [2:0]  state_q, state_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  word_q, word_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  seq_q, seq_d;
  logic        ready_q, ready_d;
  logic [15:0] hdr1_q, hdr1_d;
  logic [31:0] info_q, info_d;
  logic [15:0] csum_q, csum_d;

  logic        accept;
  logic        sending;
  logic        last_bit;
  logic [3:0]  bit_sel;
  logic [15:0] csum_calc;
  logic [15:0] cur_word;

  assign accept   = bus.info_valid_in && ready_q;
  assign sending  = (state_q == HEADER) || (state_q == DATA) || (state_q == CHECKSUM);
  assign last_bit = (bit_idx_q == 4'd15);
  assign bit_sel  = 4'd15 - bit_idx_q;

  // Checksum is taken from the live input at the accept edge, i.e. from exactly the words being latched.
  ones_complement_sum u_csum (
    .w0_i  (SYNC_WORD),
    .w1_i  ({PLAYER_ID, seq_q}),
    .w2_i  (bus.info_in[31:16]),
    .w3_i  (bus.info_in[15:0]),
    .sum_o (csum_calc)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    word_d    = word_q;
    gap_d     = gap_q;
    seq_d     = seq_q;
    hdr1_d    = hdr1_q;
    info_d    = info_q;
    csum_d    = csum_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = HEADER;
          bit_idx_d = 4'd0;
          word_d    = 3'd0;
          hdr1_d    = {PLAYER_ID, seq_q};
          info_d    = bus.info_in;
          csum_d    = csum_calc;
          seq_d     = seq_q + 8'd1;
        end
      end
      HEADER, DATA, CHECKSUM: begin
        bit_idx_d = bit_idx_q + 4'd1;
        if (last_bit) begin
          word_d = word_q + 3'd1;
          if (word_q == 3'd1) begin
            state_d = DATA;
          end else if (word_q == 3'd3) begin
            state_d = CHECKSUM;
          end else if (word_q == LAST_WORD) begin
            word_d  = 3'd0;
            gap_d   = 16'd0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == GAP_LAST) begin
          gap_d   = 16'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    cur_word = 16'd0;
    case (word_q)
      3'd0:    cur_word = SYNC_WORD;
      3'd1:    cur_word = hdr1_q;
      3'd2:    cur_word = info_q[31:16];
      3'd3:    cur_word = info_q[15:0];
      3'd4:    cur_word = csum_q;
      default: cur_word = 16'd0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      bit_idx_q <= 4'd0;
      word_q    <= 3'd0;
      gap_q     <= 16'd0;
      seq_q     <= 8'd0;
      ready_q   <= 1'b0;
      hdr1_q    <= 16'd0;
      info_q    <= 32'd0;
      csum_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      word_q    <= word_d;
      gap_q     <= gap_d;
      seq_q     <= seq_d;
      ready_q   <= ready_d;
      hdr1_q    <= hdr1_d;
      info_q    <= info_d;
      csum_q    <= csum_d;
    end
  end

  assign bus.info_ready_out = ready_q;
  assign bus.data_valid_out = sending;
  assign bus.data_out       = sending & cur_word[bit_sel];

endmodule

// File: tb/tb_player_encoder.sv
// Directed bench for player_encoder: one instance with a 16-cycle gap, one with no gap.
// Outputs are sampled and inputs driven on the falling edge.
module tb_player_encoder;
  import player_link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  player_encoder_if b0 ();
  player_encoder_if b1 ();

  player_encoder #(.PLAYER_ID(8'h03), .GAP_CYCLES(16)) dut0 (
    .clk_in (clk), .rst_in (rst), .bus (b0)
  );
  player_encoder #(.PLAYER_ID(8'h03), .GAP_CYCLES(0)) dut1 (
    .clk_in (clk), .rst_in (rst), .bus (b1)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic        sel   = 1'b0;
  logic        vld   = 1'b0;
  logic [31:0] info  = 32'd0;
  logic        rdy, dout, dvld;

  always @(posedge clk) cyc <= cyc + 1;

  assign b0.info_in       = info;
  assign b1.info_in       = info;
  assign b0.info_valid_in = vld & ~sel;
  assign b1.info_valid_in = vld & sel;
  assign rdy  = sel ? b1.info_ready_out : b0.info_ready_out;
  assign dout = sel ? b1.data_out       : b0.data_out;
  assign dvld = sel ? b1.data_valid_out : b0.data_valid_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_csum(input logic [63:0] w);
    logic [16:0] acc;
    acc = {1'b0, DEFAULT_SYNC_WORD};
    for (int k = 0; k < 4; k++) begin
      acc = {1'b0, acc[15:0]} + {1'b0, w[63-16*k -: 16]};
      if (acc[16]) acc = {1'b0, acc[15:0]} + 17'd1;
    end
    return ~acc[15:0];
  endfunction

  task automatic check_words(input string tag, input logic [79:0] bits, input logic [79:0] exp);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s_w%0d", tag, k), {16'h0, bits[79-16*k -: 16]}, {16'h0, exp[79-16*k -: 16]});
  endtask

  // Presents d (valid stays high), waits for the accept, then swaps the input to d_next
  // and samples nbits cycles of the stream starting the cycle after the accept edge.
  task automatic send_frame(input logic [31:0] d, input logic [31:0] d_next, input int nbits,
                            output logic [79:0] bits, output int acc, output int vcnt);
    int w;
    @(negedge clk);
    info = d;
    vld  = 1'b1;
    w    = 0;
    while (!rdy && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", {31'd0, rdy}, 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    info = d_next;
    bits = '0;
    vcnt = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) @(negedge clk);
      bits = {bits[78:0], dout};
      vcnt += int'(dvld);
    end
  endtask

  logic [79:0] bits;
  int          acc1, acc2, vc;
  logic [31:0] word_i;

  initial begin
    // Reset: valid asserted during reset must not start a frame.
    repeat (3) @(negedge clk);
    check("rst_ready",  {31'd0, rdy},  32'd0);
    check("rst_dvld",   {31'd0, dvld}, 32'd0);
    check("rst_dout",   {31'd0, dout}, 32'd0);
    check("rst_ready1", {31'd0, b1.info_ready_out}, 32'd0);
    vld  = 1'b1;
    info = 32'hDEADBEEF;
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, rdy},  32'd1);
    check("post_rst_dvld",  {31'd0, dvld}, 32'd0);

    // Frame with seq 0; input changes right after accept and must not leak into the frame.
    send_frame(32'h12345678, 32'hFFFFFFFF, 80, bits, acc1, vc);
    check_words("f0", bits, {16'hA55A, 16'h0300, 16'h1234, 16'h5678, 16'hEEF8});
    check("f0_vld_cycles", 32'(vc), 32'd80);
    @(negedge clk);
    check("f0_end_dvld",  {31'd0, dvld}, 32'd0);
    check("f0_end_dout",  {31'd0, dout}, 32'd0);
    check("f0_end_ready", {31'd0, rdy},  32'd0);

    // Valid held: next accept lands exactly 80 + 16 + 1 cycles later, seq 1.
    send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 80, bits, acc2, vc);
    vld = 1'b0;
    check("b2b_period", 32'(acc2 - acc1), 32'd97);
    check_words("f1", bits, {16'hA55A, 16'h0301, 16'hFFFF, 16'hFFFF, 16'h57A4});
    check("f1_vld_cycles", 32'(vc), 32'd80);

    // Abort a frame after 40 bits with reset.
    send_frame(32'hCAFEF00D, 32'hCAFEF00D, 40, bits, acc1, vc);
    vld = 1'b0;
    check("abort_vld_cycles", 32'(vc), 32'd40);
    check("abort_w1", {16'h0, bits[23:8]}, 32'h0302);
    rst = 1'b1;
    @(negedge clk);
    check("abort_dvld", {31'd0, dvld}, 32'd0);
    check("abort_dout", {31'd0, dout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, rdy}, 32'd1);

    // After abort: seq back to 0, double end-around-carry checksum.
    send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 80, bits, acc1, vc);
    vld = 1'b0;
    check_words("f2", bits, {16'hA55A, 16'h0300, 16'hFFFF, 16'hFFFF, 16'h57A5});
    check("f2_vld_cycles", 32'(vc), 32'd80);

    // No-gap instance: 257 back-to-back frames, accept every 81 cycles, seq wraps.
    sel = 1'b1;
    for (int i = 0; i < 257; i++) begin
      word_i = (32'(i) * 32'h01010101) ^ 32'h89ABCDEF;
      send_frame(word_i, word_i, 80, bits, acc2, vc);
      if (i > 0)
        check($sformatf("g0_period_%0d", i), 32'(acc2 - acc1), 32'd81);
      acc1 = acc2;
      check($sformatf("g0_vld_%0d", i), 32'(vc), 32'd80);
      check($sformatf("g0_w1_%0d", i), {16'h0, bits[63:48]}, {16'h0, 8'h03, 8'(i)});
      check($sformatf("g0_data_%0d", i), bits[47:16], word_i);
      check($sformatf("g0_csum_%0d", i), {16'h0, bits[15:0]},
            {16'h0, model_csum({8'h03, 8'(i), word_i, 16'h0000})});
    end
    check("g0_last_w1_wrapped", {16'h0, bits[63:48]}, 32'h0300);
    vld = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
